mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle main controller for the MIPS-subset CPU. It sequences the shared PC register, instruction register, ALU, data memory and register file over 2–5 cycles per instruction. It sits beside the datapath, taking opcode/funct from the instruction register and the ALU zero flag, and drives every write enable and mux select, including the PC register's write enable and next-PC select.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]; stable from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0, valid in EXEC
- ir_we  out  1  load IR from instruction memory
- pc_we  out  1  PC register write enable
- npc_sel  out  2  0 PC+4, 1 branch target, 2 jump (imm26), 3 GPR[rs]
- alu_src  out  1  0 GPR[rt], 1 extended imm16
- ext_op  out  1  0 zero-extend, 1 sign-extend
- alu_op  out  2  0 ADD, 1 SUB, 2 OR, 3 LUI (imm << 16)
- mem_we  out  1  data memory write enable
- reg_we  out  1  register file write enable
- reg_dst  out  2  0 rt, 1 rd, 2 $31
- wd_sel  out  2  0 ALU result, 1 memory data, 2 PC (link)
- state  out  3  current FSM state, for debug
- instr_done  out  1  high in the final cycle of each instruction
- retired  out  32  count of completed instructions

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Other codes return to FETCH.
- Supported: addu (0/0x21), subu (0/0x23), jr (0/0x08), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03. Anything else, including sll-nop, is a NOP.
- FETCH: ir_we=1, pc_we=1, npc_sel=0. Next state DECODE.
- DECODE:
  - j: pc_we=1, npc_sel=2.
  - jal: same as j, plus reg_we=1, reg_dst=2, wd_sel=2. The link value is the already-advanced PC, which is the instruction address + 4.
  - jr: pc_we=1, npc_sel=3.
  - j/jal/jr and NOP assert instr_done and go to FETCH. All others go to EXEC.
- EXEC:
  - beq: alu_src=0, alu_op=SUB, pc_we=zero, npc_sel=1, instr_done=1. Next state FETCH.
  - lw/sw: alu_src=1, ext_op=1, alu_op=ADD. Next state MEM.
  - addu/subu: alu_src=0, alu_op ADD/SUB. Next state WB.
  - ori: alu_src=1, ext_op=0, alu_op=OR. Next state WB.
  - lui: alu_src=1, alu_op=LUI. Next state WB.
- MEM:
  - sw: mem_we=1, instr_done=1. Next state FETCH.
  - lw: next state WB.
- WB: reg_we=1, instr_done=1. Next state FETCH.
  - R-type: reg_dst=1, wd_sel=0.
  - ori/lui: reg_dst=0, wd_sel=0.
  - lw: reg_dst=0, wd_sel=1.
- ALU/ext selects hold their EXEC values through MEM and WB. The datapath latches the ALU result into an ALUOut register.
- Outputs are a Moore/Mealy decode of state plus opcode/funct/zero. Only state and retired are registered.
- retired increments on every cycle with instr_done=1 and wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset (synchronous): state=FETCH, retired=0.
  - While reset is high, all write enables (ir_we, pc_we, mem_we, reg_we) and instr_done are forced to 0. All selects read 0.
- Reset asserted mid-instruction aborts it at the next edge. No partial write occurs after that edge.
- First fetch happens in the first cycle after reset deasserts.
- Latency in cycles: beq 3; j/jal/jr/NOP 2; addu/subu/ori/lui 4; sw 4; lw 5.
- pc_we and reg_we together in DECODE for jal: the register file is written with the pre-edge PC, so the link is correct.
- beq with zero=0: pc_we=0. The PC keeps the FETCH-incremented value.

## Structure
- Package mc_pkg holds:
  - opcode and funct constants;
  - the state encoding;
  - the npc_sel, alu_op, reg_dst and wd_sel encodings.
- Sub-module mc_decode: combinational. Maps opcode/funct to a one-hot instruction class (rtype_alu, ori, lui, lw, sw, beq, j, jal, jr, nop). mc_ctrl keys on this class.

## Test plan
- Reset held 3 cycles, then released:
  - during reset, pc_we=ir_we=0, state=0, retired=0;
  - in the first cycle after release, ir_we=pc_we=1.
- addu, then lw, then sw in sequence:
  - state traces are 0,1,2,4 / 0,1,2,3,4 / 0,1,2,3;
  - reg_we only in WB, mem_we only in sw's MEM;
  - retired reaches 3.
- beq in EXEC:
  - with zero=1: pc_we=1, npc_sel=1;
  - with zero=0: pc_we=0;
  - both cases take 3 cycles.
- jal at 0x3000: in DECODE, reg_we=1, reg_dst=2, wd_sel=2, pc_we=1, npc_sel=2. The register file receives 0x3004.
- Undefined opcode 0x3F and sll-nop (all zeros): 2 cycles each, no reg_we or mem_we, instr_done=1.
- Reset asserted in lw's MEM state: no reg_we follows, and state=FETCH after the edge. With retired preloaded to 0xFFFF_FFFF (forced), one retirement wraps it to 0.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle MIPS-subset controller.
// Rev 1.0
`default_nettype none

package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [1:0] NPC_SEQ    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_REG    = 2'd3;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_OR     = 2'd2;
  localparam logic [1:0] ALU_LUI    = 2'd3;

  localparam logic [1:0] DST_RT     = 2'd0;
  localparam logic [1:0] DST_RD     = 2'd1;
  localparam logic [1:0] DST_RA     = 2'd2;

  localparam logic [1:0] WD_ALU     = 2'd0;
  localparam logic [1:0] WD_MEM     = 2'd1;
  localparam logic [1:0] WD_PC      = 2'd2;

  typedef struct packed {
    logic rtype_alu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
  } instr_class_t;

endpackage

`default_nettype wire

// File: rtl/mc_decode.sv
// mc_decode: maps opcode/funct to a one-hot instruction class.
// Rev 1.0
`default_nettype none

module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t iclass
);

  always_comb begin
    iclass = '0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADDU || funct == FN_SUBU) iclass.rtype_alu = 1'b1;
        else if (funct == FN_JR)                  iclass.jr        = 1'b1;
        else                                      iclass.nop       = 1'b1;
      end
      OP_ORI:  iclass.ori = 1'b1;
      OP_LUI:  iclass.lui = 1'b1;
      OP_LW:   iclass.lw  = 1'b1;
      OP_SW:   iclass.sw  = 1'b1;
      OP_BEQ:  iclass.beq = 1'b1;
      OP_J:    iclass.j   = 1'b1;
      OP_JAL:  iclass.jal = 1'b1;
      default: iclass.nop = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller sequencing PC, IR, ALU, memory and regfile.
// Rev 1.0
`default_nettype none

module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  npc_sel,
  output logic        alu_src,
  output logic        ext_op,
  output logic [1:0]  alu_op,
  output logic        mem_we,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic [31:0] retired
);

  state_t       state_q;
  state_t       state_d;
  logic [31:0]  retired_q;
  instr_class_t ic;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .iclass (ic)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done) retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    state_d    = ST_FETCH;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    npc_sel    = NPC_SEQ;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    alu_op     = ALU_ADD;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = DST_RT;
    wd_sel     = WD_ALU;
    instr_done = 1'b0;

    if (!reset) begin
      // ALU selects stay at their EXEC values while ALUOut is consumed in MEM/WB
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
        if (ic.beq) begin
          alu_op = ALU_SUB;
        end else if (ic.rtype_alu) begin
          alu_op = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
        end else if (ic.ori) begin
          alu_src = 1'b1;
          alu_op  = ALU_OR;
        end else if (ic.lui) begin
          alu_src = 1'b1;
          alu_op  = ALU_LUI;
        end else if (ic.lw || ic.sw) begin
          alu_src = 1'b1;
          ext_op  = 1'b1;
        end
      end

      case (state_q)
        ST_FETCH: begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end
        ST_DECODE: begin
          if (ic.j || ic.jal) begin
            pc_we   = 1'b1;
            npc_sel = NPC_JUMP;
          end
          // PC already holds instr+4 here, so the link write sees the right value
          if (ic.jal) begin
            reg_we  = 1'b1;
            reg_dst = DST_RA;
            wd_sel  = WD_PC;
          end
          if (ic.jr) begin
            pc_we   = 1'b1;
            npc_sel = NPC_REG;
          end
          if (ic.j || ic.jal || ic.jr || ic.nop) begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (ic.beq) begin
            pc_we      = zero;
            npc_sel    = NPC_BRANCH;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else if (ic.lw || ic.sw) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_MEM: begin
          if (ic.sw) begin
            mem_we     = 1'b1;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_WB: begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
          reg_dst    = ic.rtype_alu ? DST_RD : DST_RT;
          wd_sel     = ic.lw ? WD_MEM : WD_ALU;
          state_d    = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl with a per-instruction reference model.
// Rev 1.0
`default_nettype none

module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        ir_we, pc_we, alu_src, ext_op, mem_we, reg_we, instr_done;
  logic [1:0]  npc_sel, alu_op, reg_dst, wd_sel;
  logic [2:0]  state;
  logic [31:0] retired;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_retired;

  // Tiny PC / link model standing in for the datapath
  logic [31:0] pc_m, link_m, pc_set_val;
  logic        pc_set = 1'b0;

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4, K_LW = 5;
  localparam int K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_NOP = 10;

  mc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .npc_sel    (npc_sel),
    .alu_src    (alu_src),
    .ext_op     (ext_op),
    .alu_op     (alu_op),
    .mem_we     (mem_we),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .wd_sel     (wd_sel),
    .state      (state),
    .instr_done (instr_done),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pc_set) pc_m <= pc_set_val;
    else if (pc_we) begin
      case (npc_sel)
        2'd0:    pc_m <= pc_m + 32'd4;
        2'd1:    pc_m <= pc_m + 32'h40;
        2'd2:    pc_m <= 32'h0000_5000;
        default: pc_m <= 32'h0000_6000;
      endcase
    end
    if (reg_we && wd_sel == 2'd2) link_m <= pc_m;
  end

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return (fn == 6'h21) ? K_ADDU : (fn == 6'h23) ? K_SUBU : (fn == 6'h08) ? K_JR : K_NOP;
      6'h0D: return K_ORI;
      6'h0F: return K_LUI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  function automatic int lat_of(input int k);
    if (k == K_BEQ) return 3;
    if (k == K_J || k == K_JAL || k == K_JR || k == K_NOP) return 2;
    if (k == K_LW) return 5;
    return 4;
  endfunction

  // Entered one step after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int k, lat, e_st;
    logic e_pc, e_reg, e_mem;
    logic [4:0] e_en;
    logic [1:0] e_npc, e_dst, e_wd;
    logic [2:0] e_alu;
    k   = kind_of(op, fn);
    lat = lat_of(k);
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int c = 0; c < lat; c++) begin
      #1;
      e_st  = (c <= 2) ? c : ((c == 3 && (k == K_LW || k == K_SW)) ? 3 : 4);
      e_pc  = (c == 0) || (c == 1 && (k == K_J || k == K_JAL || k == K_JR)) ||
              (c == 2 && k == K_BEQ && z);
      e_reg = (c == lat - 1) && (k == K_ADDU || k == K_SUBU || k == K_ORI ||
                                 k == K_LUI || k == K_LW || k == K_JAL);
      e_mem = (k == K_SW) && (c == 3);
      e_en  = {c == 0, e_pc, e_mem, e_reg, c == lat - 1};
      n_checks++;
      if (state !== 3'(e_st)) begin
        n_fail++;
        $display("FAIL state op=%h fn=%h cyc%0d got %0d exp %0d", op, fn, c, state, e_st);
      end
      n_checks++;
      if ({ir_we, pc_we, mem_we, reg_we, instr_done} !== e_en) begin
        n_fail++;
        $display("FAIL enables{ir,pc,mem,reg,done} op=%h fn=%h cyc%0d got %b exp %b",
                 op, fn, c, {ir_we, pc_we, mem_we, reg_we, instr_done}, e_en);
      end
      if (e_pc || (k == K_BEQ && c == 2)) begin
        e_npc = (c == 0) ? 2'd0 : (c == 2) ? 2'd1 : (k == K_JR) ? 2'd3 : 2'd2;
        n_checks++;
        if (npc_sel !== e_npc) begin
          n_fail++;
          $display("FAIL npc_sel op=%h fn=%h cyc%0d got %0d exp %0d", op, fn, c, npc_sel, e_npc);
        end
      end
      if (e_reg) begin
        e_dst = (k == K_JAL) ? 2'd2 : (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
        e_wd  = (k == K_JAL) ? 2'd2 : (k == K_LW) ? 2'd1 : 2'd0;
        n_checks++;
        if ({reg_dst, wd_sel} !== {e_dst, e_wd}) begin
          n_fail++;
          $display("FAIL reg_dst/wd_sel op=%h cyc%0d got %0d/%0d exp %0d/%0d",
                   op, c, reg_dst, wd_sel, e_dst, e_wd);
        end
      end
      if (c >= 2) begin
        case (k)
          K_ADDU:      e_alu = {1'b0, 2'd0};
          K_SUBU:      e_alu = {1'b0, 2'd1};
          K_BEQ:       e_alu = {1'b0, 2'd1};
          K_ORI:       e_alu = {1'b1, 2'd2};
          K_LUI:       e_alu = {1'b1, 2'd3};
          default:     e_alu = {1'b1, 2'd0};
        endcase
        n_checks++;
        if ({alu_src, alu_op} !== e_alu) begin
          n_fail++;
          $display("FAIL alu{src,op} op=%h cyc%0d got %b exp %b", op, c, {alu_src, alu_op}, e_alu);
        end
        if (k == K_LW || k == K_SW || k == K_ORI) begin
          n_checks++;
          if (ext_op !== (k != K_ORI)) begin
            n_fail++;
            $display("FAIL ext_op op=%h cyc%0d got %b exp %b", op, c, ext_op, k != K_ORI);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    exp_retired = exp_retired + 32'd1;
    n_checks++;
    if (retired !== exp_retired) begin
      n_fail++;
      $display("FAIL retired op=%h got %h exp %h", op, retired, exp_retired);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    opcode = 6'h23;
    funct  = 6'h00;
    zero   = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({ir_we, pc_we, mem_we, reg_we, instr_done, state} !== 8'h00 || retired !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d got en=%b state=%0d retired=%h exp zeros",
                 c, {ir_we, pc_we, mem_we, reg_we, instr_done}, state, retired);
      end
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    exp_retired = 32'd0;
    #1;
    n_checks++;
    if ({ir_we, pc_we, state} !== {1'b1, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL first_fetch got ir=%b pc=%b state=%0d exp 1 1 0", ir_we, pc_we, state);
    end
  endtask

  task automatic test_sequence();
    run_instr(6'h00, 6'h21, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0);
    run_instr(6'h2B, 6'h00, 1'b0);
    n_checks++;
    if (retired !== 32'd3) begin
      n_fail++;
      $display("FAIL seq_retired got %0d exp 3", retired);
    end
  endtask

  task automatic test_beq();
    run_instr(6'h04, 6'h00, 1'b1);
    run_instr(6'h04, 6'h00, 1'b0);
  endtask

  task automatic test_jal();
    reset      = 1'b1;
    pc_set     = 1'b1;
    pc_set_val = 32'h0000_3000;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    pc_set = 1'b0;
    exp_retired = 32'd0;
    run_instr(6'h03, 6'h00, 1'b0);
    n_checks++;
    if (link_m !== 32'h0000_3004 || pc_m !== 32'h0000_5000) begin
      n_fail++;
      $display("FAIL jal_link got link=%h pc=%h exp 00003004 00005000", link_m, pc_m);
    end
  endtask

  task automatic test_nop();
    run_instr(6'h3F, 6'h00, 1'b0);
    run_instr(6'h00, 6'h00, 1'b0);
  endtask

  task automatic test_reset_abort();
    opcode = 6'h23;
    funct  = 6'h00;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (state !== 3'd3) begin
      n_fail++;
      $display("FAIL abort_in_mem got state %0d exp 3", state);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({ir_we, pc_we, mem_we, reg_we, instr_done, npc_sel, alu_src, ext_op, alu_op,
         reg_dst, wd_sel} !== 15'd0) begin
      n_fail++;
      $display("FAIL abort_outputs got en=%b reg_dst=%0d wd_sel=%0d exp zeros",
               {ir_we, pc_we, mem_we, reg_we, instr_done}, reg_dst, wd_sel);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (state !== 3'd0 || reg_we !== 1'b0 || retired !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_after_edge got state=%0d reg_we=%b retired=%h exp 0 0 0",
               state, reg_we, retired);
    end
    reset = 1'b0;
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    exp_retired = 32'hFFFF_FFFF;
    run_instr(6'h00, 6'h00, 1'b0);
    n_checks++;
    if (retired !== 32'd0) begin
      n_fail++;
      $display("FAIL retired_wrap got %h exp 00000000", retired);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [12] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23,
                             6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F, 6'h00};
    logic [5:0] fns [12] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    int idx;
    for (int i = 0; i < 60; i++) begin
      idx = int'($urandom_range(0, 12));
      if (idx == 12) run_instr(6'($urandom), 6'($urandom), 1'($urandom));
      else           run_instr(ops[idx], fns[idx], 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_beq();
    test_nop();
    test_random();
    test_jal();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
